// File: rtl/seq_alu_pkg.sv
// Shared types for seq_alu: operation encodings, FSM states and op classification.
package seq_alu_pkg;

   localparam int OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_AND   = 4'd0,
      OP_OR    = 4'd1,
      OP_ADD   = 4'd2,
      OP_XOR   = 4'd3,
      OP_SLL   = 4'd4,
      OP_SRL   = 4'd5,
      OP_SUB   = 4'd6,
      OP_SLT   = 4'd7,
      OP_SRA   = 4'd8,
      OP_SLTU  = 4'd9,
      OP_MUL   = 4'd10,
      OP_MULHU = 4'd11,
      OP_DIVU  = 4'd12,
      OP_REMU  = 4'd13
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic is_multicycle(input logic [OP_W-1:0] op);
      return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
   endfunction

   // Division ops share the restoring datapath; the other two use shift-add.
   function automatic logic is_div(input logic [OP_W-1:0] op);
      return (op == OP_DIVU) || (op == OP_REMU);
   endfunction

   // MULHU and REMU both read the upper half of the shared accumulator.
   function automatic logic is_hi_half(input logic [OP_W-1:0] op);
      return (op == OP_MULHU) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide on one 2*WIDTH accumulator.
// Present only when SEQ_ALU_MULDIV_EN is defined.
`ifdef SEQ_ALU_MULDIV_EN
module seq_alu_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             step,
   input  logic             op_div,
   input  logic             sel_hi,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] res_nxt
);

   localparam int CNT_W = $clog2(WIDTH);

   // MUL: {product_hi, multiplier}.  DIV: {remainder, dividend/quotient}.
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0]   b_q;
   logic               div_q;
   logic               hi_q;
   logic [CNT_W-1:0]   cnt_q;

   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     partial;
   logic [WIDTH:0]     diff;
   logic               fits;

   always_comb begin
      add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
      partial = acc_q[2*WIDTH-1:WIDTH-1];
      diff    = partial - {1'b0, b_q};
      // A zero divisor always fits, so the quotient fills with ones and the
      // dividend shifts whole into the remainder.
      fits    = (partial >= {1'b0, b_q});
      if (div_q) begin
         if (fits) acc_nxt = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         else      acc_nxt = {partial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
         acc_nxt = {add_sum, acc_q[WIDTH-1:1]};
      end
      res_nxt = hi_q ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
   end

   assign done = (cnt_q == CNT_W'(WIDTH - 1));

   // NOTE: datapath registers are reset too, so an aborted iteration leaves no residue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         b_q   <= '0;
         div_q <= 1'b0;
         hi_q  <= 1'b0;
         cnt_q <= '0;
      end else if (start) begin
         acc_q <= {{WIDTH{1'b0}}, a};
         b_q   <= b;
         div_q <= op_div;
         hi_q  <= sel_hi;
         cnt_q <= '0;
      end else if (step) begin
         acc_q <= acc_nxt;
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule
`endif

// File: rtl/seq_alu.sv
// Registered RV32I/M-style ALU with valid/ready handshake.
// Define SEQ_ALU_MULDIV_EN to build the iterative MUL/MULHU/DIVU/REMU unit.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);

   state_e             state_q, state_d;
   logic               accept;
   logic               go_multi;
   logic [WIDTH-1:0]   result_q;
   logic               zero_q;
   logic               illegal_q;
   logic [WIDTH-1:0]   sc_res;
   logic               sc_illegal;
   logic [SHAMT_W-1:0] shamt;

   assign shamt  = src_b[SHAMT_W-1:0];
   assign accept = in_valid && in_ready;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      sc_res     = '0;
      sc_illegal = 1'b0;
      case (op)
         OP_AND:  sc_res = src_a & src_b;
         OP_OR:   sc_res = src_a | src_b;
         OP_XOR:  sc_res = src_a ^ src_b;
         OP_ADD:  sc_res = src_a + src_b;
         OP_SUB:  sc_res = src_a - src_b;
         OP_SLT:  sc_res = WIDTH'($signed(src_a) < $signed(src_b));
         OP_SLTU: sc_res = WIDTH'(src_a < src_b);
         OP_SLL:  sc_res = src_a << shamt;
         OP_SRL:  sc_res = src_a >> shamt;
         OP_SRA:  sc_res = WIDTH'($signed(src_a) >>> shamt);
         default: sc_illegal = 1'b1;
      endcase
   end

`ifdef SEQ_ALU_MULDIV_EN
   logic             md_done;
   logic [WIDTH-1:0] md_res;

   assign go_multi = is_multicycle(op);

   seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (accept && go_multi),
      .step    (state_q == ST_BUSY),
      .op_div  (is_div(op)),
      .sel_hi  (is_hi_half(op)),
      .a       (src_a),
      .b       (src_b),
      .done    (md_done),
      .res_nxt (md_res)
   );
`else
   assign go_multi = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) state_d = go_multi ? ST_BUSY : ST_DONE;
         end
`ifdef SEQ_ALU_MULDIV_EN
         ST_BUSY: begin
            if (md_done) state_d = ST_DONE;
         end
`endif
         ST_DONE: begin
            // Back-to-back handoff skips IDLE entirely.
            if (accept)         state_d = go_multi ? ST_BUSY : ST_DONE;
            else if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
      out_valid = (state_q == ST_DONE);
      result    = result_q;
      zero      = zero_q;
      illegal   = illegal_q;
   end

   // Result flags change only when a new result is produced, so DONE holds them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q  <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else if (accept && !go_multi) begin
         result_q  <= sc_res;
         zero_q    <= (sc_res == '0);
         illegal_q <= sc_illegal;
      end
`ifdef SEQ_ALU_MULDIV_EN
      else if ((state_q == ST_BUSY) && md_done) begin
         result_q  <= md_res;
         zero_q    <= (md_res == '0);
         illegal_q <= 1'b0;
      end
`endif
   end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vector table, randomized ops against
// an arithmetic reference model, backpressure/handoff and mid-operation reset.
module tb_seq_alu;
   import seq_alu_pkg::*;

   localparam int W = 32;
`ifdef SEQ_ALU_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   op;
   logic [W-1:0] src_a;
   logic [W-1:0] src_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         zero;
   logic         illegal;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .src_a     (src_a),
      .src_b     (src_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: plain arithmetic on the operation's definition.
   function automatic void model(input logic [3:0] m_op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic ill, output int lat);
      longint unsigned prod;
      logic [63:0]     p;
      int              sh;
      prod = longint'(a) * longint'(b);
      p    = prod;
      sh   = int'(b % 32);
      ill  = 1'b0;
      lat  = 1;
      r    = '0;
      case (m_op)
         4'd0:  r = a & b;
         4'd1:  r = a | b;
         4'd2:  r = a + b;
         4'd3:  r = a ^ b;
         4'd4:  r = a << sh;
         4'd5:  r = a >> sh;
         4'd6:  r = a - b;
         4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd8:  r = $signed(a) >>> sh;
         4'd9:  r = (a < b) ? 32'd1 : 32'd0;
         4'd10: r = p[31:0];
         4'd11: r = p[63:32];
         4'd12: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         4'd13: r = (b == 0) ? a : a % b;
         default: ill = 1'b1;
      endcase
      if (m_op >= 4'd10 && m_op <= 4'd13) begin
         if (MD) lat = W + 1;
         else begin
            r   = '0;
            ill = 1'b1;
         end
      end
   endfunction

   // Issue one op with out_ready high; lat counts rising edges from accept to out_valid.
   task automatic run_op(input logic [3:0] t_op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic z, output logic ill, output int lat);
      int guard;
      @(negedge clk);
      op        = t_op;
      src_a     = a;
      src_b     = b;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      guard     = 0;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) check("accept_timeout", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      src_a    = $urandom;
      src_b    = $urandom;
      lat      = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      r   = result;
      z   = zero;
      ill = illegal;
   endtask

   typedef struct {
      string        name;
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
   } vec_t;

   vec_t tbl[15];

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] r, exp_r;
      logic         z, ill, exp_ill;
      int           lat, exp_lat;

      tbl[0]  = '{"add_wrap",  OP_ADD,   32'hFFFF_FFFF, 32'd1,         32'd0};
      tbl[1]  = '{"slt",       OP_SLT,   32'hFFFF_FFFF, 32'd1,         32'd1};
      tbl[2]  = '{"sltu",      OP_SLTU,  32'hFFFF_FFFF, 32'd1,         32'd0};
      tbl[3]  = '{"sub_neg",   OP_SUB,   32'd5,         32'd7,         32'hFFFF_FFFE};
      tbl[4]  = '{"sra",       OP_SRA,   32'h8000_0000, 32'd4,         32'hF800_0000};
      tbl[5]  = '{"srl",       OP_SRL,   32'h8000_0000, 32'd4,         32'h0800_0000};
      tbl[6]  = '{"sll_wrap",  OP_SLL,   32'd1,         32'd33,        32'd2};
      tbl[7]  = '{"xor",       OP_XOR,   32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555};
      tbl[8]  = '{"mul_lo",    OP_MUL,   32'h0001_0000, 32'h0001_0000, 32'd0};
      tbl[9]  = '{"mulhu",     OP_MULHU, 32'h0001_0000, 32'h0001_0000, MD ? 32'd1 : 32'd0};
      tbl[10] = '{"divu_by0",  OP_DIVU,  32'd7,         32'd0,         MD ? 32'hFFFF_FFFF : 32'd0};
      tbl[11] = '{"remu_by0",  OP_REMU,  32'd7,         32'd0,         MD ? 32'd7 : 32'd0};
      tbl[12] = '{"divu",      OP_DIVU,  32'd100,       32'd7,         MD ? 32'd14 : 32'd0};
      tbl[13] = '{"remu",      OP_REMU,  32'd100,       32'd7,         MD ? 32'd2 : 32'd0};
      tbl[14] = '{"undef_op",  4'd14,    32'd3,         32'd4,         32'd0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op        = '0;
      src_a     = '0;
      src_b     = '0;
      repeat (2) @(negedge clk);
      check("rst_in_ready",  in_ready,  1);
      check("rst_out_valid", out_valid, 0);
      check("rst_result",    result,    0);
      check("rst_zero",      zero,      0);
      check("rst_illegal",   illegal,   0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         exp_ill = (tbl[i].op >= 4'd14) || (tbl[i].op >= 4'd10 && !MD);
         exp_lat = (tbl[i].op >= 4'd10 && tbl[i].op <= 4'd13 && MD) ? W + 1 : 1;
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, r, z, ill, lat);
         check({tbl[i].name, "_result"},  r,   tbl[i].res);
         check({tbl[i].name, "_zero"},    z,   tbl[i].res == 0);
         check({tbl[i].name, "_illegal"}, ill, exp_ill);
         check({tbl[i].name, "_latency"}, lat, exp_lat);
      end

      for (int n = 0; n < 150; n++) begin
         logic [3:0]   rop;
         logic [W-1:0] ra, rb;
         rop = 4'($urandom_range(0, 15));
         ra  = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = '0;
            1:       rb = W'($urandom_range(1, 15));
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) ra = W'($urandom_range(0, 300));
         model(rop, ra, rb, exp_r, exp_ill, exp_lat);
         run_op(rop, ra, rb, r, z, ill, lat);
         check($sformatf("rand%0d_op%0d_result", n, rop), r, exp_r);
         check($sformatf("rand%0d_op%0d_zero", n, rop), z, exp_r == 0);
         check($sformatf("rand%0d_op%0d_illegal", n, rop), ill, exp_ill);
         check($sformatf("rand%0d_op%0d_latency", n, rop), lat, exp_lat);
      end

      // Backpressure: result held while out_ready is low, then same-cycle handoff.
      @(negedge clk);
      op        = OP_SUB;
      src_a     = 32'd10;
      src_b     = 32'd3;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      src_a    = 32'hDEAD_BEEF;
      check("bp_valid", out_valid, 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("bp_hold_result_%0d", k), result, 32'd7);
         check($sformatf("bp_hold_in_ready_%0d", k), in_ready, 0);
         check($sformatf("bp_hold_valid_%0d", k), out_valid, 1);
      end
      op        = OP_ADD;
      src_a     = 32'd2;
      src_b     = 32'd3;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      check("handoff_in_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      check("handoff_valid",  out_valid, 1);
      check("handoff_result", result,    32'd5);

      // Reset in the middle of a DIVU (about ten iterations in).
      @(negedge clk);
      op        = OP_DIVU;
      src_a     = 32'd100;
      src_b     = 32'd7;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("mid_busy_valid", out_valid, !MD);
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready",  in_ready,  1);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_result",    result,    0);
      check("mid_rst_zero",      zero,      0);
      check("mid_rst_illegal",   illegal,   0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(OP_ADD, 32'd2, 32'd3, r, z, ill, lat);
      check("post_rst_add_result",  r,   32'd5);
      check("post_rst_add_latency", lat, 1);
      run_op(OP_MUL, 32'd6, 32'd7, r, z, ill, lat);
      check("post_rst_mul_result",  r,   MD ? 32'd42 : 32'd0);
      check("post_rst_mul_illegal", ill, !MD);
      check("post_rst_mul_latency", lat, MD ? W + 1 : 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, registered ALU for the next-generation RISC-V core. It takes operands through a valid/ready handshake and supports the full RV32I/M-style integer set. Single-cycle ops return their result one cycle after acceptance. MUL/DIV/REM run on an iterative shift-add / restoring datapath. It replaces the combinational 3-bit-control ALU on the execute stage of the multi-cycle core.

Parameters:
WIDTH, 32, operand/result width in bits (>=8, power of two)
SHAMT_W, $clog2(WIDTH), shift-amount bits taken from src_b LSBs

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/op valid
in_ready  output  1  block can accept a new op
op  input  4  operation code (see package)
src_a  input  WIDTH  operand A
src_b  input  WIDTH  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  result
zero  output  1  result == 0
illegal  output  1  op unsupported in this build

Behaviour:
- Reset value of every output: 0, except in_ready, which is 1. Reset is asynchronous. Assertion mid-operation aborts any iteration, returns the FSM to IDLE and discards partial state.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch op/src_a/src_b. Single-cycle op -> DONE next cycle with result registered. MUL/MULHU/DIVU/REMU -> BUSY with cnt=0.
  - BUSY: one iteration per cycle. cnt counts 0..WIDTH-1; at cnt==WIDTH-1 -> DONE. Multi-cycle latency from accept to out_valid is WIDTH+1 cycles.
  - DONE: out_valid=1. result, zero and illegal are held stable until out_ready. If out_ready is low, stay in DONE. If out_ready is high, go to IDLE.
- in_ready is 1 in IDLE, and 1 in DONE when out_ready=1 (back-to-back accept). A simultaneous handoff goes directly to the new op's next state; no bubble.
- Single-cycle ops:
  - AND, OR, XOR, ADD, SUB: wrap modulo 2^WIDTH.
  - SLT: signed compare; SLTU: unsigned compare. Both return 1 or 0 zero-extended.
  - SLL, SRL, SRA: shift by src_b[SHAMT_W-1:0].
- MUL returns the low WIDTH bits of the unsigned product. MULHU returns the high WIDTH bits. The shared 2*WIDTH accumulator implements shift-add.
- DIVU/REMU use restoring division with a shared remainder register.
  - Divide by zero: DIVU = all-ones, REMU = src_a. BUSY still takes the full WIDTH cycles.
- zero = (result == 0) for every op, including SLT and MUL. This replaces the old SUB-only zero flag.
- Undefined op codes: result=0, illegal=1, single-cycle.
- in_valid while not in_ready: ignored; the source must hold it.
- Operands are latched at accept. Changes on src_a/src_b during BUSY have no effect.

Optional Feature:
SEQ_ALU_MULDIV_EN
- Defined: MUL, MULHU, DIVU and REMU are implemented as above, along with the BUSY state and the iteration datapath.
- Undefined: the BUSY logic and accumulators are compiled out. Those four codes behave as undefined ops: one-cycle, result=0, illegal=1.

Decomposition:
- Package seq_alu_pkg holds:
  - the 4-bit op encodings: AND=0, OR=1, ADD=2, XOR=3, SLL=4, SRL=5, SUB=6, SLT=7, SRA=8, SLTU=9, MUL=10, MULHU=11, DIVU=12, REMU=13;
  - the FSM state typedef (IDLE, BUSY, DONE);
  - a function is_multicycle(op).
- One sub-module, seq_alu_muldiv, holds the iterative unit: start, op_div, a, b, cnt, done, prod/quot/rem registers. It sits inside the `ifdef.

Test Plan:
1. ADD, WIDTH=32: src_a=0xFFFFFFFF, src_b=1, out_ready=1 -> out_valid 1 cycle after accept, result=0, zero=1.
2. SLT vs SLTU: src_a=0xFFFFFFFF, src_b=1 -> SLT result=1, SLTU result=0.
3. MUL: 0x0001_0000 x 0x0001_0000 -> out_valid after 33 cycles; MUL=0, zero=1; MULHU=1.
4. Divide by zero: DIVU 7/0 -> 0xFFFFFFFF. REMU 7/0 -> 7. DIVU 100/7 -> 14; REMU -> 2.
5. Backpressure: out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0. Then out_ready=1 with in_valid=1 -> new op accepted that same cycle.
6. Reset mid-DIVU at cnt=10 -> all outputs 0, in_ready=1. A following ADD 2+3 -> 5. Without the macro: op=MUL -> illegal=1, result=0, one cycle.
